// File: rtl/uart_rx_os16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os16_pkg
// Description : Shared oversampling constants and state codes for the 16x
//               UART receiver (and the companion transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_os16_pkg;

    localparam int         OS_RATE = 16;
    localparam logic [3:0] OS_MID  = 4'(OS_RATE / 2 - 1);
    localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Bits needed to count 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_os16_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os16_sync
// Description : Multi-flop synchronizer for the asynchronous rx line.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os16_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Preset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_os16.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os16
// Description : 16x-oversampling UART receiver with valid/ready byte output,
//               framing-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os16
    import uart_rx_os16_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick16,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int                BCNT_W     = cnt_width(DATA_BITS);
    localparam logic [BCNT_W-1:0] C_LAST_BIT = BCNT_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_state_t          r_state;
    uart_state_t          w_state_next;
    logic [3:0]           r_os_cnt;
    logic [3:0]           w_os_cnt_next;
    logic [BCNT_W-1:0]    r_bit_cnt;
    logic [BCNT_W-1:0]    w_bit_cnt_next;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] w_shreg_next;
    logic                 w_byte_done;
    logic                 w_stop_err;
    logic                 r_byte_done;

    uart_rx_os16_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (w_rx_s)
    );

    always_comb begin
        w_state_next   = r_state;
        w_os_cnt_next  = r_os_cnt;
        w_bit_cnt_next = r_bit_cnt;
        w_shreg_next   = r_shreg;
        w_byte_done    = 1'b0;
        w_stop_err     = 1'b0;
        if (tick16) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_next  = ST_START;
                        w_os_cnt_next = '0;
                    end
                end
                ST_START: begin
                    if (r_os_cnt == OS_MID) begin
                        w_os_cnt_next = '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        if (!w_rx_s) begin
                            w_state_next   = ST_DATA;
                            w_bit_cnt_next = '0;
                        end else begin
                            w_state_next   = ST_IDLE;
                        end
                    end else begin
                        w_os_cnt_next = r_os_cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (r_os_cnt == OS_LAST) begin
                        w_shreg_next   = {w_rx_s, r_shreg[DATA_BITS-1:1]};
                        w_os_cnt_next  = '0;
                        w_bit_cnt_next = r_bit_cnt + BCNT_W'(1);
                        if (r_bit_cnt == C_LAST_BIT) begin
                            w_state_next = ST_STOP;
                        end
                    end else begin
                        w_os_cnt_next = r_os_cnt + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (r_os_cnt == OS_LAST) begin
                        w_os_cnt_next = '0;
                        w_state_next  = ST_IDLE;
                        w_byte_done   = w_rx_s;
                        w_stop_err    = ~w_rx_s;
                    end else begin
                        w_os_cnt_next = r_os_cnt + 4'd1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_byte_done <= 1'b0;
            rx_busy     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_os_cnt    <= w_os_cnt_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shreg     <= w_shreg_next;
            r_byte_done <= w_byte_done;
            rx_busy     <= (w_state_next != ST_IDLE);
            frame_err   <= w_stop_err;
        end
    end

    // Output holding register: an unconsumed byte is never overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (r_byte_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= r_shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_os16
// Description : Self-checking bench for uart_rx_os16 against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os16;

    localparam int CLK_DIV = 4;
    localparam int TPB     = 16;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       tick16   = 1'b0;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    // Observed events
    logic [7:0] got_q[$];
    int         ferr_cnt  = 0;
    int         ovr_cnt   = 0;
    int         busy_cnt  = 0;
    bit         both_seen = 0;
    bit         wide_seen = 0;
    bit         prev_ferr = 0;
    bit         prev_ovr  = 0;

    // Frame-level reference model
    logic [7:0] exp_q[$];
    bit         m_valid    = 0;
    logic [7:0] m_data     = 8'h00;
    int         exp_ferr   = 0;
    int         exp_ovr    = 0;
    bit         ready_tied = 0;

    uart_rx_os16 #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick16    (tick16),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin : g_tickgen
        logic [1:0] div;
        div = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            div    = div + 2'd1;
            tick16 = (div == 2'd0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (frame_err && overrun) both_seen = 1;
            if ((frame_err && prev_ferr) || (overrun && prev_ovr)) wide_seen = 1;
            if (rx_busy) busy_cnt++;
        end
        prev_ferr = frame_err;
        prev_ovr  = overrun;
    end

    initial begin : g_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n * CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit stop);
        if (!stop) begin
            exp_ferr++;
        end else if (ready_tied || !m_valid) begin
            m_data = d;
            if (ready_tied) exp_q.push_back(d);
            else            m_valid = 1;
        end else begin
            exp_ovr++;
        end
    endtask

    task automatic model_consume();
        if (m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop);
        rx = 1'b0;
        wait_ticks(TPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_ticks(TPB);
        end
        rx = stop;
        wait_ticks(TPB);
        rx = 1'b1;
        model_frame(d, stop);
    endtask

    task automatic pulse_ready();
        @(posedge clk); #1;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        model_consume();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h required 000",
                     {rx_data, rx_valid, rx_busy, frame_err, overrun});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ticks(20);
        checks++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b valid=%b required 0/0", rx_busy, rx_valid);
        end
    endtask

    task automatic test_basic();
        int b0;
        ready_tied = 0;
        rx_ready   = 1'b0;
        b0 = busy_cnt;
        send_frame(8'h55, 1'b1);
        wait_ticks(4);
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
            errors++;
            $display("FAIL basic_byte valid=%b data=%h required 1/55", rx_valid, rx_data);
        end
        // Busy spans start detection to the stop sample: about 9.5 bits.
        checks++;
        if ((busy_cnt - b0) < 148 * CLK_DIV || (busy_cnt - b0) > 156 * CLK_DIV) begin
            errors++;
            $display("FAIL basic_busy_len got %0d clk required %0d..%0d",
                     busy_cnt - b0, 148 * CLK_DIV, 156 * CLK_DIV);
        end
        wait_ticks(40);
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_hold valid=%b required 1", rx_valid);
        end
        pulse_ready();
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h55) begin
            errors++;
            $display("FAIL basic_consume valid=%b data=%h required 0/55", rx_valid, rx_data);
        end
        checks++;
        if (ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin
            errors++;
            $display("FAIL basic_flags ferr=%0d ovr=%0d required %0d/%0d",
                     ferr_cnt, ovr_cnt, exp_ferr, exp_ovr);
        end
    endtask

    task automatic compare_queues(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got %0d required %0d", name, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s_byte%0d got %h required %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[$];
        ready_tied = 1;
        rx_ready   = 1'b1;
        got_q.delete();
        exp_q.delete();
        bytes = '{8'hA3, 8'h0F};
        for (int i = 0; i < 3; i++) bytes.push_back(8'($urandom));
        foreach (bytes[i]) send_frame(bytes[i], 1'b1);
        wait_ticks(8);
        @(negedge clk);
        compare_queues("b2b");
        checks++;
        if (ovr_cnt !== exp_ovr || ferr_cnt !== exp_ferr || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_flags ovr=%0d ferr=%0d valid=%b required %0d/%0d/0",
                     ovr_cnt, ferr_cnt, rx_valid, exp_ovr, exp_ferr);
        end
        rx_ready   = 1'b0;
        ready_tied = 0;
    endtask

    task automatic test_glitch();
        int b0;
        b0 = busy_cnt;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(20);
        @(negedge clk);
        checks++;
        if (rx_valid !== m_valid || ferr_cnt !== exp_ferr || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_state valid=%b ferr=%0d busy=%b required %b/%0d/0",
                     rx_valid, ferr_cnt, rx_busy, m_valid, exp_ferr);
        end
        // Busy from detection to the mid-start check: about 8 ticks.
        checks++;
        if ((busy_cnt - b0) < 6 * CLK_DIV || (busy_cnt - b0) > 10 * CLK_DIV) begin
            errors++;
            $display("FAIL glitch_busy_len got %0d clk required %0d..%0d",
                     busy_cnt - b0, 6 * CLK_DIV, 10 * CLK_DIV);
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0);
        wait_ticks(24);
        @(negedge clk);
        checks++;
        if (ferr_cnt !== exp_ferr) begin
            errors++;
            $display("FAIL ferr_count got %0d required %0d", ferr_cnt, exp_ferr);
        end
        checks++;
        if (rx_valid !== m_valid || rx_data !== m_data) begin
            errors++;
            $display("FAIL ferr_untouched valid=%b data=%h required %b/%h",
                     rx_valid, rx_data, m_valid, m_data);
        end
    endtask

    task automatic test_overrun();
        ready_tied = 0;
        rx_ready   = 1'b0;
        send_frame(8'h11, 1'b1);
        wait_ticks(6);
        send_frame(8'h22, 1'b1);
        wait_ticks(8);
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11 || ovr_cnt !== exp_ovr) begin
            errors++;
            $display("FAIL overrun_keep valid=%b data=%h ovr=%0d required 1/11/%0d",
                     rx_valid, rx_data, ovr_cnt, exp_ovr);
        end
        pulse_ready();
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_consume valid=%b required 0", rx_valid);
        end
        compare_queues("ovr");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'h77;
        ready_tied = 1;
        rx_ready   = 1'b1;
        rx = 1'b0;
        wait_ticks(TPB);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            wait_ticks(TPB);
        end
        @(negedge clk);
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy got %b required 1", rx_busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
            errors++;
            $display("FAIL midframe_reset got %h required 000",
                     {rx_data, rx_valid, rx_busy, frame_err, overrun});
        end
        @(posedge clk); #1;
        rst     = 1'b0;
        m_valid = 0;
        m_data  = 8'h00;
        wait_ticks(20);
        send_frame(8'h81, 1'b1);
        wait_ticks(8);
        @(negedge clk);
        compare_queues("rstmid");
        rx_ready   = 1'b0;
        ready_tied = 0;
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit         stop;
        for (int n = 0; n < 6; n++) begin
            if (m_valid && $urandom_range(0, 1) == 1) pulse_ready();
            ready_tied = !m_valid && ($urandom_range(0, 1) == 1);
            rx_ready   = ready_tied;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop);
            wait_ticks($urandom_range(4, 20));
            @(negedge clk);
            checks++;
            if (rx_valid !== (m_valid && !ready_tied) || rx_data !== m_data) begin
                errors++;
                $display("FAIL rand%0d_out valid=%b data=%h required %b/%h (sent %h stop=%b)",
                         n, rx_valid, rx_data, m_valid, m_data, d, stop);
            end
            rx_ready   = 1'b0;
            ready_tied = 0;
        end
        if (m_valid) pulse_ready();
        @(negedge clk);
        compare_queues("rand");
        checks++;
        if (ferr_cnt !== exp_ferr || ovr_cnt !== exp_ovr) begin
            errors++;
            $display("FAIL rand_flags ferr=%0d ovr=%0d required %0d/%0d",
                     ferr_cnt, ovr_cnt, exp_ferr, exp_ovr);
        end
    endtask

    task automatic test_pulse_shape();
        checks++;
        if (both_seen !== 1'b0 || wide_seen !== 1'b0) begin
            errors++;
            $display("FAIL pulse_shape both=%b wide=%b required 0/0", both_seen, wide_seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_random();
        test_pulse_shape();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
